pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Next-generation hazard and pipeline-control unit for the 5-stage AXI MIPS core.
- Adds a parametrised register-address width and a parametrised exception vector.
- Replaces the external divider-ready handshake with an internal multi-cycle MDU countdown FSM.
- Adds an exception-pending latch, so a redirect raised during an I/D-cache stall is deferred, never lost, and fires exactly once.
- Sits beside the datapath and drives all stall, flush, forward and redirect controls.

Parameters:
- AW, 5: register-address width.
- MDU_LAT, 32: cycles a multi-cycle MDU op (div/divu) occupies E. Must be >=1.
- EXC_VEC, 32'hBFC00380: exception entry PC.
- ERET_CODE, 32'h0000000E: excepttype value meaning ERET (redirect to EPC).

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous active-low reset
- rsD, rtD  in  AW  D-stage source registers
- branchD, jrD  in  1  D-stage branch / jump-register
- rsE, rtE, writeregE  in  AW  E-stage sources / destination
- regwriteE, memtoregE  in  1  E write-enable / load
- mdu_startE  in  1  multi-cycle MDU op present in E
- writeregM  in  AW;  regwriteM, memtoregM  in  1  M-stage destination / controls
- writeregW  in  AW;  regwriteW  in  1  W-stage destination / write-enable
- excepttypeM, epcM  in  32  exception code / EPC from M
- i_stall, d_stall  in  1  AXI instruction / data cache busy
- forwardaD, forwardbD  out  1  D-stage forward from M
- forwardaE, forwardbE  out  2  00 register file, 10 from M, 01 from W
- stallF, stallD, stallE, stallM, stallW  out  1  per-stage stalls
- flushF, flushD, flushE, flushM, flushW  out  1  per-stage flushes
- pc_redirect  out  1  one-cycle redirect strobe
- newpc  out  32  redirect target, valid when pc_redirect=1
- mdu_busy  out  1  MDU FSM not IDLE

Behaviour:
Forwarding (combinational):
- forwardaD = rsD!=0 & rsD==writeregM & regwriteM. forwardbD is the same using rtD.
- forwardaE: 10 if rsE!=0 & rsE==writeregM & regwriteM; else 01 if rsE!=0 & rsE==writeregW & regwriteW; else 00. M has priority over W. forwardbE is the same using rtE.

Hazard terms:
- lwstall = memtoregE & (rtE==rsD | rtE==rtD).
- brstall = branchD & ((regwriteE & (writeregE==rsD | writeregE==rtD)) | (memtoregM & (writeregM==rsD | writeregM==rtD))).
- jrstall = jrD & regwriteE & writeregE==rsD.
- dstall = lwstall | brstall | jrstall.

MDU FSM (states IDLE / BUSY / DONE, counter cnt):
- IDLE: mdu_startE & ~exc_fire -> BUSY, cnt=MDU_LAT-1.
- BUSY: cnt decrements every cycle, including during cache stalls. At cnt==0 -> DONE.
- DONE: ~i_stall & ~d_stall -> IDLE; otherwise hold DONE.
- mdu_stall = mdu_startE & (state!=DONE). stallE is therefore high for exactly MDU_LAT+1 cycles when no cache stall occurs.
- exc_fire in any state -> IDLE next edge.
- mdu_busy = state!=IDLE.

Stall outputs:
- longest = i_stall | d_stall | mdu_stall.
- stallF = stallD = dstall | longest.
- stallE = stallM = stallW = longest.

Exception handling:
- exc_now = excepttypeM!=0.
- If exc_now & longest: latch pend=1, pcode=excepttypeM, pepc=epcM.
- exc_fire = (exc_now | pend) & ~longest.
- On exc_fire:
  - all five flush outputs = 1 and pc_redirect = 1 for that cycle only.
  - pend clears next edge.
  - Flush overrides stall in that cycle.
- Redirect target: code = pend ? pcode : excepttypeM. newpc = (code==ERET_CODE) ? (pend ? pepc : epcM) : EXC_VEC.
  - Any other nonzero code, including undefined ones, goes to EXC_VEC.
  - newpc = 0 when not firing. No latches are inferred.

Other flushes:
- flushE = exc_fire | (dstall & ~longest). A bubble is never inserted into a frozen E.
- flushF, flushD, flushM, flushW = exc_fire.

Reset (resetn=0 at a clk edge, including mid-BUSY or with pend set):
- MDU FSM -> IDLE, cnt=0, pend=0, pcode=0, pepc=0.
- Registered outputs read 0 the following cycle. Combinational outputs follow their inputs.

Test Plan:
- Load-use: memtoregE=1, rtE=5, rsD=5, no cache stall -> stallF=stallD=1, flushE=1 for 1 cycle, stallE=0.
- Forward priority: rsE=3, writeregM=writeregW=3, regwriteM=regwriteW=1 -> forwardaE=10. With regwriteM=0 -> 01. With rsE=0 -> 00.
- MDU with MDU_LAT=4: mdu_startE held high -> stallE high exactly 5 cycles, mdu_busy high 5 cycles, FSM back to IDLE after DONE. Add d_stall high 3 cycles during BUSY -> release waits for d_stall to drop.
- Deferred exception: excepttypeM=1 while d_stall=1 for 4 cycles, then excepttypeM returns to 0 -> no flush during stall, then one cycle with all flushes=1, pc_redirect=1, newpc=BFC00380; no second pulse.
- ERET: excepttypeM=0000000E, epcM=80001234, no stall -> pc_redirect=1, newpc=80001234. Undefined code 00000003 -> newpc=BFC00380.
- Reset mid-op: resetn=0 for 1 cycle during BUSY with pend=1 -> next cycle mdu_busy=0, pc_redirect=0, all flushes 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard detection, forwarding, MDU countdown and deferred-exception redirect for a 5-stage MIPS pipeline
module pipe_hazard_ctrl #(
  parameter int          AW        = 5,
  parameter int          MDU_LAT   = 32,
  parameter logic [31:0] EXC_VEC   = 32'hBFC00380,
  parameter logic [31:0] ERET_CODE = 32'h0000000E
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [AW-1:0] rsD,
  input  logic [AW-1:0] rtD,
  input  logic          branchD,
  input  logic          jrD,
  input  logic [AW-1:0] rsE,
  input  logic [AW-1:0] rtE,
  input  logic [AW-1:0] writeregE,
  input  logic          regwriteE,
  input  logic          memtoregE,
  input  logic          mdu_startE,
  input  logic [AW-1:0] writeregM,
  input  logic          regwriteM,
  input  logic          memtoregM,
  input  logic [AW-1:0] writeregW,
  input  logic          regwriteW,
  input  logic [31:0]   excepttypeM,
  input  logic [31:0]   epcM,
  input  logic          i_stall,
  input  logic          d_stall,
  output logic          forwardaD,
  output logic          forwardbD,
  output logic [1:0]    forwardaE,
  output logic [1:0]    forwardbE,
  output logic          stallF,
  output logic          stallD,
  output logic          stallE,
  output logic          stallM,
  output logic          stallW,
  output logic          flushF,
  output logic          flushD,
  output logic          flushE,
  output logic          flushM,
  output logic          flushW,
  output logic          pc_redirect,
  output logic [31:0]   newpc,
  output logic          mdu_busy
);
  localparam int CW = (MDU_LAT > 1) ? $clog2(MDU_LAT) : 1;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          pend;
  logic [31:0]   pcode, pepc, code;
  logic          lwstall, brstall, jrstall, dstall, mdu_stall, longest, exc_now, exc_fire;
  assign forwardaD = (rsD != '0) && (rsD == writeregM) && regwriteM;
  assign forwardbD = (rtD != '0) && (rtD == writeregM) && regwriteM;
  assign forwardaE = ((rsE != '0) && (rsE == writeregM) && regwriteM) ? 2'b10 :
                     ((rsE != '0) && (rsE == writeregW) && regwriteW) ? 2'b01 : 2'b00;
  assign forwardbE = ((rtE != '0) && (rtE == writeregM) && regwriteM) ? 2'b10 :
                     ((rtE != '0) && (rtE == writeregW) && regwriteW) ? 2'b01 : 2'b00;
  assign lwstall   = memtoregE && ((rtE == rsD) || (rtE == rtD));
  assign brstall   = branchD && ((regwriteE && ((writeregE == rsD) || (writeregE == rtD))) ||
                                 (memtoregM && ((writeregM == rsD) || (writeregM == rtD))));
  assign jrstall   = jrD && regwriteE && (writeregE == rsD);
  assign dstall    = lwstall || brstall || jrstall;
  assign mdu_stall = mdu_startE && (state != DONE);
  assign longest   = i_stall || d_stall || mdu_stall;
  assign exc_now   = excepttypeM != '0;
  assign exc_fire  = (exc_now || pend) && !longest;
  assign mdu_busy  = state != IDLE;
  assign stallF    = (dstall || longest) && !exc_fire;
  assign stallD    = stallF;
  assign stallE    = longest;
  assign stallM    = longest;
  assign stallW    = longest;
  assign flushF    = exc_fire;
  assign flushD    = exc_fire;
  assign flushE    = exc_fire || (dstall && !longest);
  assign flushM    = exc_fire;
  assign flushW    = exc_fire;
  assign pc_redirect = exc_fire;
  assign code      = pend ? pcode : excepttypeM;
  assign newpc     = !exc_fire ? 32'h0 : (code == ERET_CODE) ? (pend ? pepc : epcM) : EXC_VEC;
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (exc_fire) begin
      state_n = IDLE;
    end else if (state == IDLE && mdu_startE) begin
      state_n = BUSY;
      cnt_n   = CW'(MDU_LAT - 1);
    end else if (state == BUSY) begin
      state_n = (cnt == '0) ? DONE : BUSY;
      cnt_n   = (cnt == '0) ? cnt : cnt - 1'b1;
    end else if (state == DONE && !i_stall && !d_stall) begin
      state_n = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      cnt   <= '0;
      pend  <= 1'b0;
      pcode <= '0;
      pepc  <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (exc_fire) begin
        pend <= 1'b0;
      end else if (exc_now && longest) begin
        pend  <= 1'b1;
        pcode <= excepttypeM;
        pepc  <= epcM;
      end
    end
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
  logic        clk = 1'b0, resetn;
  logic [4:0]  rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
  logic        branchD, jrD, regwriteE, memtoregE, mdu_startE, regwriteM, memtoregM, regwriteW;
  logic [31:0] excepttypeM, epcM;
  logic        i_stall, d_stall;
  logic        forwardaD, forwardbD;
  logic [1:0]  forwardaE, forwardbE;
  logic        stallF, stallD, stallE, stallM, stallW;
  logic        flushF, flushD, flushE, flushM, flushW;
  logic        pc_redirect, mdu_busy;
  logic [31:0] newpc;
  logic [4:0]  fl;
  int          n_checks = 0, n_fail = 0;
  assign fl = {flushF, flushD, flushE, flushM, flushW};
  always #5 clk = ~clk;
  pipe_hazard_ctrl #(.MDU_LAT(4)) dut (
    .clk(clk), .resetn(resetn), .rsD(rsD), .rtD(rtD), .branchD(branchD), .jrD(jrD),
    .rsE(rsE), .rtE(rtE), .writeregE(writeregE), .regwriteE(regwriteE), .memtoregE(memtoregE),
    .mdu_startE(mdu_startE), .writeregM(writeregM), .regwriteM(regwriteM), .memtoregM(memtoregM),
    .writeregW(writeregW), .regwriteW(regwriteW), .excepttypeM(excepttypeM), .epcM(epcM),
    .i_stall(i_stall), .d_stall(d_stall), .forwardaD(forwardaD), .forwardbD(forwardbD),
    .forwardaE(forwardaE), .forwardbE(forwardbE), .stallF(stallF), .stallD(stallD),
    .stallE(stallE), .stallM(stallM), .stallW(stallW), .flushF(flushF), .flushD(flushD),
    .flushE(flushE), .flushM(flushM), .flushW(flushW), .pc_redirect(pc_redirect),
    .newpc(newpc), .mdu_busy(mdu_busy)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic idle_inputs();
    {rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW} = '0;
    {branchD, jrD, regwriteE, memtoregE, mdu_startE, regwriteM, memtoregM, regwriteW} = '0;
    excepttypeM = '0;
    epcM = '0;
    i_stall = 1'b0;
    d_stall = 1'b0;
  endtask
  initial begin
    idle_inputs();
    resetn = 1'b0;
    cyc();
    cyc();
    resetn = 1'b1;
    #1;
    check("rst_busy", 32'(mdu_busy), 32'd0);
    check("rst_redirect", 32'(pc_redirect), 32'd0);
    check("rst_flush", 32'(fl), 32'd0);
    check("rst_stall", 32'({stallF, stallD, stallE, stallM, stallW}), 32'd0);
    check("rst_newpc", newpc, 32'd0);
    // load-use
    memtoregE = 1'b1; rtE = 5'd5; rsD = 5'd5;
    #1;
    check("lu_stallFD", 32'({stallF, stallD}), 32'd3);
    check("lu_flushE", 32'(flushE), 32'd1);
    check("lu_stallE", 32'(stallE), 32'd0);
    check("lu_flushF", 32'(flushF), 32'd0);
    cyc();
    idle_inputs();
    #1;
    check("lu_release", 32'({stallF, flushE}), 32'd0);
    // forwarding
    rsE = 5'd3; writeregM = 5'd3; writeregW = 5'd3; regwriteM = 1'b1; regwriteW = 1'b1; rsD = 5'd3;
    #1;
    check("fwdaE_M", 32'(forwardaE), 32'd2);
    check("fwdaD_M", 32'(forwardaD), 32'd1);
    regwriteM = 1'b0; rtE = 5'd3;
    #1;
    check("fwdaE_W", 32'(forwardaE), 32'd1);
    check("fwdbE_W", 32'(forwardbE), 32'd1);
    check("fwdaD_off", 32'(forwardaD), 32'd0);
    rsE = 5'd0; writeregW = 5'd0;
    #1;
    check("fwdaE_r0", 32'(forwardaE), 32'd0);
    idle_inputs();
    // branch and jr hazards
    branchD = 1'b1; regwriteE = 1'b1; writeregE = 5'd7; rtD = 5'd7; rsD = 5'd1;
    #1;
    check("br_stall", 32'({stallD, flushE}), 32'd3);
    branchD = 1'b0; jrD = 1'b1; rsD = 5'd7;
    #1;
    check("jr_stall", 32'({stallF, flushE}), 32'd3);
    idle_inputs();
    cyc();
    // MDU, no cache stall
    for (int i = 0; i < 7; i++) begin
      mdu_startE = (i < 6);
      #1;
      check($sformatf("mdu_stallE_%0d", i), 32'(stallE), 32'(i < 5));
      check($sformatf("mdu_busy_%0d", i), 32'(mdu_busy), 32'(i >= 1 && i <= 5));
      cyc();
    end
    idle_inputs();
    cyc();
    // MDU with d_stall during BUSY
    for (int i = 0; i < 8; i++) begin
      mdu_startE = (i < 7);
      d_stall = (i >= 3 && i <= 5);
      #1;
      check($sformatf("mdud_stallE_%0d", i), 32'(stallE), 32'(i <= 5));
      check($sformatf("mdud_busy_%0d", i), 32'(mdu_busy), 32'(i >= 1 && i <= 6));
      cyc();
    end
    idle_inputs();
    cyc();
    // deferred exception
    for (int i = 0; i < 4; i++) begin
      excepttypeM = 32'h1; epcM = 32'h8000_0100; d_stall = 1'b1;
      #1;
      check($sformatf("dx_noflush_%0d", i), 32'(fl), 32'd0);
      check($sformatf("dx_noredir_%0d", i), 32'(pc_redirect), 32'd0);
      cyc();
    end
    idle_inputs();
    #1;
    check("dx_flush", 32'(fl), 32'h1F);
    check("dx_redirect", 32'(pc_redirect), 32'd1);
    check("dx_newpc", newpc, 32'hBFC00380);
    cyc();
    check("dx_once", 32'(pc_redirect), 32'd0);
    check("dx_once_fl", 32'(fl), 32'd0);
    // deferred ERET uses latched EPC
    for (int i = 0; i < 2; i++) begin
      excepttypeM = 32'hE; epcM = 32'h8000_5678; i_stall = 1'b1;
      cyc();
    end
    idle_inputs();
    #1;
    check("dxe_newpc", newpc, 32'h8000_5678);
    cyc();
    check("dxe_once", 32'(pc_redirect), 32'd0);
    // immediate ERET / undefined code, flush overrides D hazard
    excepttypeM = 32'hE; epcM = 32'h8000_1234; memtoregE = 1'b1; rtE = 5'd4; rsD = 5'd4;
    #1;
    check("eret_redir", 32'(pc_redirect), 32'd1);
    check("eret_newpc", newpc, 32'h8000_1234);
    check("eret_nostallF", 32'(stallF), 32'd0);
    excepttypeM = 32'h3;
    #1;
    check("undef_newpc", newpc, 32'hBFC00380);
    check("undef_flush", 32'(fl), 32'h1F);
    idle_inputs();
    cyc();
    // reset mid-BUSY with pend set
    mdu_startE = 1'b1;
    cyc();
    excepttypeM = 32'h1; d_stall = 1'b1;
    #1;
    check("rm_busy", 32'(mdu_busy), 32'd1);
    cyc();
    excepttypeM = 32'h0; resetn = 1'b0;
    cyc();
    resetn = 1'b1; d_stall = 1'b0; mdu_startE = 1'b0;
    #1;
    check("rm_busy0", 32'(mdu_busy), 32'd0);
    check("rm_redir0", 32'(pc_redirect), 32'd0);
    check("rm_flush0", 32'(fl), 32'd0);
    check("rm_newpc0", newpc, 32'd0);
    cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
